// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared FSM state, strobe levels and default timeout for the Z80 slot front end.
package z80_bus_pkg;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, READ, WRITE} state_t;
    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_INACTIVE = 1'b1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/z80_bus_sync_ff.sv
// sync_ff: multi-stage synchronizer for a bundle of asynchronous inputs.
module sync_ff #(
    parameter int WIDTH = 1,
    parameter int STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/z80_bus_sync.sv
// z80_bus_sync: synchronizes the Z80 slot bus into SLOTCLK and turns each slot memory
// cycle into one read or write strobe with latched address/data.
module z80_bus_sync
    import z80_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        SLOTCLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        RD,
    input  logic        WR,
    input  logic        MREQ,
    input  logic        IORQ,
    input  logic        M1,
    input  logic        RFSH,
    input  logic        EXSLTSLX,
    output logic [15:0] BUS_A,
    output logic [7:0]  BUS_D,
    output logic        MEM_RD_STB,
    output logic        MEM_WR_STB,
    output logic        ROM_OE_N,
    output logic        BDIR,
    output logic        CYCLE_ACTIVE,
    output logic        TIMEOUT
);
    logic        rd_s, wr_s, mreq_s, iorq_s, m1_s, rfsh_s, sltsl_s;
    logic [15:0] a_s;
    logic [7:0]  d_s;
    logic        start, cyc_end, to_hit, unused_m1;
    state_t      state_q;
    logic [15:0] bus_a_q;
    logic [7:0]  bus_d_q, cnt_q, flush_q;
    logic        rd_stb_q, wr_stb_q, rom_oe_n_q, bdir_q, active_q, timeout_q;

    sync_ff #(.WIDTH(7), .STAGES(SYNC_STAGES), .RESET_VAL({7{STROBE_INACTIVE}})) u_sync_strb (
        .clk_i(SLOTCLK), .rst_i(RESET),
        .d_i({RD, WR, MREQ, IORQ, M1, RFSH, EXSLTSLX}),
        .q_o({rd_s, wr_s, mreq_s, iorq_s, m1_s, rfsh_s, sltsl_s})
    );

    sync_ff #(.WIDTH(24), .STAGES(SYNC_STAGES), .RESET_VAL(24'h0)) u_sync_bus (
        .clk_i(SLOTCLK), .rst_i(RESET), .d_i({A, D}), .q_o({a_s, d_s})
    );

    assign unused_m1 = m1_s;
    assign start = ~sltsl_s & ~mreq_s & rfsh_s & iorq_s;
    assign cyc_end = mreq_s | sltsl_s | (state_q == READ ? rd_s : wr_s);
    assign to_hit = (cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES);

    // flush_q keeps WAIT_IDLE from trusting the synchronizer's reset value while it refills
    always_ff @(posedge SLOTCLK) begin
        if (RESET) begin
            state_q    <= WAIT_IDLE;
            bus_a_q    <= '0;
            bus_d_q    <= '0;
            cnt_q      <= '0;
            flush_q    <= 8'(SYNC_STAGES);
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            rom_oe_n_q <= 1'b1;
            bdir_q     <= 1'b0;
            active_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            timeout_q <= 1'b0;
            flush_q   <= (flush_q != 8'd0) ? flush_q - 8'd1 : 8'd0;
            case (state_q)
                WAIT_IDLE: if (flush_q == 8'd0 && mreq_s && rd_s && wr_s) state_q <= IDLE;
                IDLE: if (start && (rd_s != wr_s)) begin
                    state_q  <= rd_s ? WRITE : READ;
                    bus_a_q  <= a_s;
                    cnt_q    <= '0;
                    active_q <= 1'b1;
                    if (rd_s) begin
                        bus_d_q  <= d_s;
                        wr_stb_q <= 1'b1;
                    end else begin
                        rd_stb_q   <= 1'b1;
                        rom_oe_n_q <= 1'b0;
                        bdir_q     <= 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q + {7'd0, cnt_q != 8'hFF};
                    if (cyc_end || to_hit) begin
                        state_q    <= WAIT_IDLE;
                        timeout_q  <= ~cyc_end;
                        rom_oe_n_q <= 1'b1;
                        bdir_q     <= 1'b0;
                        active_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign BUS_A        = bus_a_q;
    assign BUS_D        = bus_d_q;
    assign MEM_RD_STB   = rd_stb_q;
    assign MEM_WR_STB   = wr_stb_q;
    assign ROM_OE_N     = rom_oe_n_q;
    assign BDIR         = bdir_q;
    assign CYCLE_ACTIVE = active_q;
    assign TIMEOUT      = timeout_q;
endmodule

// File: tb/tb_z80_bus_sync.sv
// tb_z80_bus_sync: scoreboard bench; stimulus queues expected slot cycles, a monitor checks each strobe.
module tb_z80_bus_sync;
    localparam int SYNC = 2;
    localparam int T = 15;
    localparam int LAT = SYNC + 1;

    typedef struct {
        bit          is_wr;
        logic [15:0] a;
        logic [7:0]  d;
        int          at;
        int          dur;
        int          oe;
        bit          to;
    } ev_t;

    logic clk = 0, rst = 1;
    logic [15:0] a = 0;
    logic [7:0] d = 0;
    logic rd = 1, wr = 1, mreq = 1, iorq = 1, m1 = 1, rfsh = 1, sltsl = 1;
    logic [15:0] bus_a;
    logic [7:0] bus_d;
    logic rd_stb, wr_stb, rom_oe_n, bdir, active, tmo;
    int cyc = 0;
    int checks = 0, errors = 0;
    logic [7:0] m_d = 0;
    ev_t q[$];

    z80_bus_sync #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .SLOTCLK(clk), .RESET(rst), .A(a), .D(d), .RD(rd), .WR(wr), .MREQ(mreq),
        .IORQ(iorq), .M1(m1), .RFSH(rfsh), .EXSLTSLX(sltsl),
        .BUS_A(bus_a), .BUS_D(bus_d), .MEM_RD_STB(rd_stb), .MEM_WR_STB(wr_stb),
        .ROM_OE_N(rom_oe_n), .BDIR(bdir), .CYCLE_ACTIVE(active), .TIMEOUT(tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic idle_bus();
        rd = 1; wr = 1; mreq = 1; iorq = 1; m1 = 1; rfsh = 1; sltsl = 1;
    endtask

    // kind: 0 read, 1 write, 2 refresh, 3 I/O write, 4 RD+WR both low, 5 unselected read
    task automatic bus_cycle(int kind, logic [15:0] addr, logic [7:0] data, int h);
        ev_t e;
        step();
        a = addr;
        d = data;
        case (kind)
            0: begin mreq = 0; rd = 0; sltsl = 0; m1 = 1'($urandom_range(0, 1)); end
            1: begin mreq = 0; wr = 0; sltsl = 0; end
            2: begin mreq = 0; rfsh = 0; sltsl = 0; end
            3: begin iorq = 0; wr = 0; sltsl = 0; end
            4: begin mreq = 0; rd = 0; wr = 0; sltsl = 0; end
            default: begin mreq = 0; rd = 0; end
        endcase
        if (kind < 2) begin
            e.is_wr = (kind == 1);
            e.a = addr;
            e.d = (kind == 1) ? data : m_d;
            e.at = cyc + LAT;
            e.dur = (h <= T) ? h : T;
            e.oe = (kind == 0) ? e.dur : 0;
            e.to = (h > T);
            q.push_back(e);
            if (kind == 1) m_d = data;
        end
        repeat (h) step();
        idle_bus();
        repeat ($urandom_range(3, 6)) step();
    endtask

    initial begin : monitor
        ev_t e;
        int dur, oe;
        wait (!rst);
        forever begin
            @(negedge clk);
            if (rd_stb || wr_stb) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: rd=%0b wr=%0b a=%0h at cycle %0d, none required", rd_stb, wr_stb, bus_a, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_kind_wr", {31'd0, wr_stb}, {31'd0, e.is_wr});
                    chk("strobe_kind_rd", {31'd0, rd_stb}, {31'd0, !e.is_wr});
                    chk("strobe_latency", cyc, e.at);
                    chk("bus_a", {16'd0, bus_a}, {16'd0, e.a});
                    chk("bus_d", {24'd0, bus_d}, {24'd0, e.d});
                    dur = 0;
                    oe = 0;
                    while (active && dur < 400) begin
                        if (dur > 0 && (rd_stb || wr_stb)) begin
                            errors++;
                            $display("FAIL repeat_strobe: second strobe inside one cycle at %0d", cyc);
                        end
                        if (rom_oe_n == bdir) begin
                            errors++;
                            $display("FAIL oe_bdir: ROM_OE_N=%0b BDIR=%0b at cycle %0d", rom_oe_n, bdir, cyc);
                        end
                        dur++;
                        oe += int'(!rom_oe_n);
                        @(negedge clk);
                    end
                    chk("active_cycles", dur, e.dur);
                    chk("oe_cycles", oe, e.oe);
                    chk("timeout_pulse", {31'd0, tmo}, {31'd0, e.to});
                end
            end else if (active || tmo || !rom_oe_n || bdir) begin
                errors++;
                $display("FAIL idle_outputs: active=%0b timeout=%0b oe_n=%0b bdir=%0b at cycle %0d", active, tmo, rom_oe_n, bdir, cyc);
            end
        end
    end

    initial begin : stim
        ev_t e;
        int c0;
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        chk("reset_outputs", {2'b0, rd_stb, wr_stb, active, tmo, bdir, rom_oe_n, bus_a, bus_d}, {7'b0, 1'b1, 24'h0});
        step();
        bus_cycle(0, 16'h6000, 8'h00, 12);
        bus_cycle(1, 16'h7000, 8'h05, 8);
        bus_cycle(2, 16'h0042, 8'h00, 6);
        bus_cycle(3, 16'h0098, 8'h11, 6);
        bus_cycle(0, 16'h6123, 8'h00, 40);
        bus_cycle(4, 16'h6000, 8'h00, 8);
        bus_cycle(0, 16'h4abc, 8'h00, T);
        bus_cycle(0, 16'h4abd, 8'h00, T + 1);
        bus_cycle(1, 16'h7fff, 8'hc3, T + 1);
        // reset for one cycle in the middle of a write, with WR still low afterwards
        step();
        c0 = cyc;
        a = 16'h7123; d = 8'ha5; mreq = 0; wr = 0; sltsl = 0;
        e.is_wr = 1; e.a = 16'h7123; e.d = 8'ha5; e.at = c0 + LAT; e.dur = 4; e.oe = 0; e.to = 0;
        q.push_back(e);
        repeat (6) step();
        rst = 1;
        step();
        rst = 0;
        m_d = 0;
        @(negedge clk);
        chk("midreset_outputs", {2'b0, rd_stb, wr_stb, active, tmo, bdir, rom_oe_n, bus_a, bus_d}, {7'b0, 1'b1, 24'h0});
        repeat (8) step();
        idle_bus();
        repeat (4) step();
        bus_cycle(1, 16'h7001, 8'h3c, 6);
        bus_cycle(0, 16'h6001, 8'h00, 6);
        repeat (60) bus_cycle(int'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), int'($urandom_range(2, 24)));
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
